// File: rtl/rob_wb_arbiter_pkg.sv
// Shared types and constants for the ROB writeback arbiter.
// Optional age-ordered scan: ROB_AGE_PRIO_EN.
package rob_wb_arbiter_pkg;

    localparam int REQ_NUM   = 5;
    localparam int PORT_NUM  = 2;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 5;
    localparam int ROB_DEPTH = 16;
    localparam int IDX_W     = $clog2(REQ_NUM);

    localparam logic [TAG_W-1:0] TAG_INVALID = {1'b1, {(TAG_W-1){1'b0}}};

    localparam int REQ_ALU = 0;
    localparam int REQ_FWD = 1;
    localparam int REQ_JMP = 2;
    localparam int REQ_BRN = 3;
    localparam int REQ_MEM = 4;

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] npc;
        logic              npc_en;
    } rob_wr_req_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] npc;
        logic              npc_en;
    } rob_wr_port_t;

    localparam rob_wr_port_t PORT_IDLE = '{
        valid:  1'b0,
        tag:    TAG_INVALID,
        val:    '0,
        npc:    '0,
        npc_en: 1'b0
    };

    function automatic idx_t idx_wrap(int v);
        return idx_t'(v % REQ_NUM);
    endfunction

endpackage

// File: rtl/rob_wb_arbiter_rr_multi_grant.sv
// Multi-grant selector: walks an index list from a start position
// and hands out up to PORT_NUM one-hot grants in scan order.
module rr_multi_grant
    import rob_wb_arbiter_pkg::*;
(
    input  logic [REQ_NUM-1:0]                req,
    input  idx_t                              start,
    input  logic [REQ_NUM-1:0][IDX_W-1:0]     order,
    output logic [PORT_NUM-1:0][REQ_NUM-1:0]  gnt,
    output idx_t                              last,
    output logic                              any
);

    int   cnt;
    idx_t idx;

    always_comb begin
        gnt  = '0;
        last = '0;
        any  = 1'b0;
        cnt  = 0;
        idx  = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = order[idx_wrap(int'(start) + k)];
            if (req[idx] && cnt < PORT_NUM) begin
                for (int p = 0; p < PORT_NUM; p++) begin
                    if (p == cnt) gnt[p][idx] = 1'b1;
                end
                last = idx;
                any  = 1'b1;
                cnt  = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Arbitrates execute/writeback results onto PORT_NUM registered ROB ports.
// Define ROB_AGE_PRIO_EN to scan oldest-first instead of round-robin.
module rob_wb_arbiter
    import rob_wb_arbiter_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         rob_busy,
    input  logic [TAG_W-2:0]             rob_head,
    input  logic [REQ_NUM-1:0]           req_valid,
    output logic [REQ_NUM-1:0]           req_ready,
    input  logic [REQ_NUM*TAG_W-1:0]     req_tag,
    input  logic [REQ_NUM*DATA_W-1:0]    req_val,
    input  logic [REQ_NUM*DATA_W-1:0]    req_npc,
    input  logic [REQ_NUM-1:0]           req_npc_en,
    output logic [PORT_NUM-1:0]          wr_valid,
    output logic [PORT_NUM*TAG_W-1:0]    wr_tag,
    output logic [PORT_NUM*DATA_W-1:0]   wr_val,
    output logic [PORT_NUM*DATA_W-1:0]   wr_npc,
    output logic [PORT_NUM-1:0]          wr_npc_en,
    output logic                         dup_err
);

    rob_wr_req_t                     req [REQ_NUM];
    rob_wr_port_t                    nxt [PORT_NUM];
    rob_wr_port_t                    q   [PORT_NUM];
    logic [REQ_NUM-1:0]              elig;
    logic [REQ_NUM-1:0]              drop;
    logic [REQ_NUM-1:0]              sel_req;
    logic [REQ_NUM-1:0]              granted;
    logic [PORT_NUM-1:0][REQ_NUM-1:0] gnt;
    logic [REQ_NUM-1:0][IDX_W-1:0]   order;
    idx_t                            start;
    idx_t                            gnt_last;
    idx_t                            rr_ptr;
    logic                            gnt_any;
    logic                            stall;
    logic                            dup_hit;

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            req[i].tag    = req_tag[i*TAG_W +: TAG_W];
            req[i].val    = req_val[i*DATA_W +: DATA_W];
            req[i].npc    = req_npc[i*DATA_W +: DATA_W];
            req[i].npc_en = req_npc_en[i];
            elig[i] = req_valid[i] & ~req[i].tag[TAG_W-1];
            drop[i] = req_valid[i] &  req[i].tag[TAG_W-1];
        end
    end

    assign stall   = rob_busy | flush;
    assign sel_req = stall ? '0 : elig;

`ifdef ROB_AGE_PRIO_EN
    // Stable rank by distance from head; ties resolve to the lower index.
    logic [TAG_W-2:0] key [REQ_NUM];
    int               rnk;
    logic             unused_ptr;

    always_comb begin
        order = '0;
        rnk   = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            key[i] = req[i].tag[TAG_W-2:0] - rob_head;
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            rnk = 0;
            for (int j = 0; j < REQ_NUM; j++) begin
                if (key[j] < key[i] || (key[j] == key[i] && j < i))
                    rnk = rnk + 1;
            end
            for (int r = 0; r < REQ_NUM; r++) begin
                if (r == rnk) order[r] = idx_t'(i);
            end
        end
    end

    assign start      = '0;
    assign unused_ptr = ^gnt_last ^ gnt_any;
`else
    logic unused_head;

    always_comb begin
        for (int k = 0; k < REQ_NUM; k++) order[k] = idx_t'(k);
    end

    assign start       = rr_ptr;
    assign unused_head = ^rob_head;
`endif

    rr_multi_grant u_sel (
        .req   (sel_req),
        .start (start),
        .order (order),
        .gnt   (gnt),
        .last  (gnt_last),
        .any   (gnt_any)
    );

    always_comb begin
        granted = '0;
        dup_hit = 1'b0;
        for (int p = 0; p < PORT_NUM; p++) begin
            granted = granted | gnt[p];
            nxt[p]  = PORT_IDLE;
            for (int i = 0; i < REQ_NUM; i++) begin
                if (gnt[p][i]) begin
                    nxt[p].valid  = 1'b1;
                    nxt[p].tag    = req[i].tag;
                    nxt[p].val    = req[i].val;
                    nxt[p].npc    = req[i].npc;
                    nxt[p].npc_en = req[i].npc_en;
                end
            end
        end
        for (int a = 0; a < PORT_NUM; a++) begin
            for (int b = a + 1; b < PORT_NUM; b++) begin
                if (nxt[a].valid && nxt[b].valid && nxt[a].tag == nxt[b].tag)
                    dup_hit = 1'b1;
            end
        end
    end

    assign req_ready = stall ? '0 : (granted | drop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < PORT_NUM; p++) q[p] <= PORT_IDLE;
            rr_ptr  <= '0;
            dup_err <= 1'b0;
        end else if (flush) begin
            for (int p = 0; p < PORT_NUM; p++) q[p] <= PORT_IDLE;
        end else if (!rob_busy) begin
            for (int p = 0; p < PORT_NUM; p++) q[p] <= nxt[p];
`ifndef ROB_AGE_PRIO_EN
            if (gnt_any) rr_ptr <= idx_wrap(int'(gnt_last) + 1);
`endif
            if (dup_hit) dup_err <= 1'b1;
        end
    end

    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            wr_valid[p]                  = q[p].valid;
            wr_tag[p*TAG_W +: TAG_W]     = q[p].tag;
            wr_val[p*DATA_W +: DATA_W]   = q[p].val;
            wr_npc[p*DATA_W +: DATA_W]   = q[p].npc;
            wr_npc_en[p]                 = q[p].npc_en;
        end
    end

endmodule
